reg_access_arbiter: RTL and testbench

//  Shares the single-port 256x8 configuration register memory of the 64-QAM modulator

---
 rtl/reg_access_arbiter_if.sv | 47 ++++
 rtl/reg_access_arbiter.sv | 114 +++++++++++
 tb/tb_reg_access_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_access_arbiter_if.sv
// Bus bundle between the register-access arbiter, its two requesters and the
// 256x8 register memory. "slave" is the arbiter's view; "master" is the environment's view.
interface reg_access_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int MEM_AW = 8,
    parameter int DATA_W = 8
);
    logic              spi_req;
    logic              spi_we;
    logic [ADDR_W-1:0] spi_addr;
    logic [DATA_W-1:0] spi_wdata;
    logic              spi_gnt;
    logic              spi_rvalid;
    logic [DATA_W-1:0] spi_rdata;
    logic              spi_err;

    logic              mod_req;
    logic [ADDR_W-1:0] mod_addr;
    logic              mod_gnt;
    logic              mod_rvalid;
    logic [DATA_W-1:0] mod_rdata;
    logic              mod_err;

    logic              mem_en;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  spi_req, spi_we, spi_addr, spi_wdata,
        output spi_gnt, spi_rvalid, spi_rdata, spi_err,
        input  mod_req, mod_addr,
        output mod_gnt, mod_rvalid, mod_rdata, mod_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output spi_req, spi_we, spi_addr, spi_wdata,
        input  spi_gnt, spi_rvalid, spi_rdata, spi_err,
        output mod_req, mod_addr,
        input  mod_gnt, mod_rvalid, mod_rdata, mod_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/reg_access_arbiter.sv
// Arbitrates the single-port configuration register memory between the SPI slave
// (read/write, normally preferred) and the modulator fetch (read-only, starvation-guarded).
module reg_access_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int MEM_AW   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic                 SCLK,
    input  logic                 rst_n,
    reg_access_arbiter_if.slave  bus
);

    typedef enum logic {
        SPI_PRI = 1'b0,
        MOD_PRI = 1'b1
    } pri_e;

    localparam int               WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    pri_e              state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic spi_gnt, mod_gnt;
    logic spi_in_range, mod_in_range;

    logic              spi_rv_q, spi_err_q, mod_rv_q, mod_err_q;
    logic [DATA_W-1:0] spi_hold_q, mod_hold_q;
    logic [DATA_W-1:0] spi_rdata, mod_rdata;

    // Grant, priority next-state and memory strobe are one combinational decision.
    // NOTE: every output is given a default first so no path leaves it unassigned (no latch).
    always_comb begin
        spi_gnt      = 1'b0;
        mod_gnt      = 1'b0;
        state_d      = state_q;
        wait_d       = wait_q;
        spi_in_range = (bus.spi_addr[ADDR_W-1:MEM_AW] == '0);
        mod_in_range = (bus.mod_addr[ADDR_W-1:MEM_AW] == '0);

        if (rst_n) begin
            if (bus.spi_req && bus.mod_req) begin
                if (state_q == MOD_PRI) mod_gnt = 1'b1;
                else                    spi_gnt = 1'b1;
            end else begin
                spi_gnt = bus.spi_req;
                mod_gnt = bus.mod_req;
            end
        end

        // A lost datapath cycle ages the request; reaching the limit flips priority for one win.
        if (mod_gnt) begin
            wait_d  = '0;
            state_d = SPI_PRI;
        end else if (bus.mod_req) begin
            if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
            if (wait_d == WAIT_MAX) state_d = MOD_PRI;
        end

        bus.spi_gnt   = spi_gnt;
        bus.mod_gnt   = mod_gnt;
        bus.mem_en    = (spi_gnt && spi_in_range) || (mod_gnt && mod_in_range);
        bus.mem_we    = spi_gnt && spi_in_range && bus.spi_we;
        bus.mem_addr  = mod_gnt ? bus.mod_addr[MEM_AW-1:0] : bus.spi_addr[MEM_AW-1:0];
        bus.mem_wdata = bus.spi_wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same cycle.
    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SPI_PRI;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Response pipeline: one cycle behind the grant, matching the synchronous memory read.
    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            spi_rv_q   <= 1'b0;
            spi_err_q  <= 1'b0;
            mod_rv_q   <= 1'b0;
            mod_err_q  <= 1'b0;
            spi_hold_q <= '0;
            mod_hold_q <= '0;
        end else begin
            spi_rv_q  <= spi_gnt && !bus.spi_we;
            spi_err_q <= spi_gnt && !spi_in_range;
            mod_rv_q  <= mod_gnt;
            mod_err_q <= mod_gnt && !mod_in_range;
            if (spi_rv_q) spi_hold_q <= spi_rdata;
            if (mod_rv_q) mod_hold_q <= mod_rdata;
        end
    end

    // Out-of-range reads never touched the memory, so they return zero instead of stale data.
    always_comb begin
        spi_rdata = spi_hold_q;
        mod_rdata = mod_hold_q;
        if (spi_rv_q) spi_rdata = spi_err_q ? '0 : bus.mem_rdata;
        if (mod_rv_q) mod_rdata = mod_err_q ? '0 : bus.mem_rdata;

        bus.spi_rvalid = spi_rv_q;
        bus.spi_err    = spi_err_q;
        bus.spi_rdata  = spi_rdata;
        bus.mod_rvalid = mod_rv_q;
        bus.mod_err    = mod_err_q;
        bus.mod_rdata  = mod_rdata;
    end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Scoreboard bench for reg_access_arbiter: a grant/priority model plus a register shadow
// predict every grant, memory strobe and read response cycle by cycle.
module tb_reg_access_arbiter;

    localparam int ADDR_W   = 10;
    localparam int MEM_AW   = 8;
    localparam int DATA_W   = 8;
    localparam int MAX_WAIT = 4;

    typedef struct {
        logic       s_rv;
        logic       s_err;
        logic [7:0] s_data;
        logic       m_rv;
        logic       m_err;
        logic [7:0] m_data;
    } resp_t;

    logic tb_clk = 1'b0;
    logic rst_n  = 1'b0;
    always #5 tb_clk = ~tb_clk;

    reg_access_arbiter_if #(.ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .DATA_W(DATA_W)) bus ();

    reg_access_arbiter #(
        .ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .SCLK  (tb_clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Synchronous single-port register memory
    logic [7:0] mem [256];
    always @(posedge tb_clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    logic [7:0] shadow [256];
    resp_t      sb_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         m_wait;
    bit         m_modpri;
    logic [7:0] last_s, last_m;

    logic       obs_spi_gnt, obs_mod_gnt, obs_mem_en;
    logic       obs_s_rv, obs_s_err, obs_m_rv, obs_m_err;
    logic [7:0] obs_s_rd, obs_m_rd;

    task automatic idle_inputs();
        bus.spi_req   = 1'b0;
        bus.spi_we    = 1'b0;
        bus.spi_addr  = '0;
        bus.spi_wdata = '0;
        bus.mod_req   = 1'b0;
        bus.mod_addr  = '0;
    endtask

    task automatic model_reset();
        resp_t z;
        z = '{default: '0};
        m_wait   = 0;
        m_modpri = 1'b0;
        last_s   = 8'h00;
        last_m   = 8'h00;
        sb_q.delete();
        sb_q.push_back(z);
    endtask

    task automatic spi_access(input logic we, input logic [9:0] addr, input logic [7:0] wdata);
        bus.spi_req   = 1'b1;
        bus.spi_we    = we;
        bus.spi_addr  = addr;
        bus.spi_wdata = wdata;
    endtask

    task automatic mod_read(input logic [9:0] addr);
        bus.mod_req  = 1'b1;
        bus.mod_addr = addr;
    endtask

    // One clock cycle: sample at the falling edge, score against the model, advance to posedge+1.
    task automatic tick();
        resp_t      e, nx;
        logic       m_s, m_m, s_in, m_in, x_en, x_we;
        logic [7:0] xs, xm, x_addr;
        @(negedge tb_clk);
        obs_spi_gnt = bus.spi_gnt;
        obs_mod_gnt = bus.mod_gnt;
        obs_mem_en  = bus.mem_en;
        obs_s_rv    = bus.spi_rvalid;
        obs_s_err   = bus.spi_err;
        obs_s_rd    = bus.spi_rdata;
        obs_m_rv    = bus.mod_rvalid;
        obs_m_err   = bus.mod_err;
        obs_m_rd    = bus.mod_rdata;

        s_in = (bus.spi_addr[9:8] == 2'b00);
        m_in = (bus.mod_addr[9:8] == 2'b00);
        m_s  = bus.spi_req && !(bus.mod_req && m_modpri);
        m_m  = bus.mod_req && !m_s;
        n_cmp++;
        if ({obs_spi_gnt, obs_mod_gnt} !== {m_s, m_m}) begin
            n_bad++;
            $display("FAIL gnt @%0t: got spi=%b mod=%b, want spi=%b mod=%b",
                     $time, obs_spi_gnt, obs_mod_gnt, m_s, m_m);
        end

        x_en = (m_s && s_in) || (m_m && m_in);
        x_we = m_s && s_in && bus.spi_we;
        n_cmp++;
        if ({bus.mem_en, bus.mem_we} !== {x_en, x_we}) begin
            n_bad++;
            $display("FAIL mem_strobe @%0t: got en=%b we=%b, want en=%b we=%b",
                     $time, bus.mem_en, bus.mem_we, x_en, x_we);
        end
        if (x_en) begin
            x_addr = m_m ? bus.mod_addr[7:0] : bus.spi_addr[7:0];
            n_cmp++;
            if (bus.mem_addr !== x_addr || (x_we && bus.mem_wdata !== bus.spi_wdata)) begin
                n_bad++;
                $display("FAIL mem_bus @%0t: got addr=%h wdata=%h, want addr=%h wdata=%h",
                         $time, bus.mem_addr, bus.mem_wdata, x_addr, bus.spi_wdata);
            end
        end

        if (sb_q.size() == 0) e = '{default: '0};
        else                  e = sb_q.pop_front();
        xs = e.s_rv ? e.s_data : last_s;
        xm = e.m_rv ? e.m_data : last_m;
        n_cmp++;
        if ({obs_s_rv, obs_s_err, obs_s_rd} !== {e.s_rv, e.s_err, xs}) begin
            n_bad++;
            $display("FAIL spi_resp @%0t: got rv=%b err=%b rd=%h, want rv=%b err=%b rd=%h",
                     $time, obs_s_rv, obs_s_err, obs_s_rd, e.s_rv, e.s_err, xs);
        end
        n_cmp++;
        if ({obs_m_rv, obs_m_err, obs_m_rd} !== {e.m_rv, e.m_err, xm}) begin
            n_bad++;
            $display("FAIL mod_resp @%0t: got rv=%b err=%b rd=%h, want rv=%b err=%b rd=%h",
                     $time, obs_m_rv, obs_m_err, obs_m_rd, e.m_rv, e.m_err, xm);
        end
        last_s = xs;
        last_m = xm;

        nx = '{default: '0};
        if (m_s) begin
            nx.s_err = !s_in;
            if (!bus.spi_we) begin
                nx.s_rv   = 1'b1;
                nx.s_data = s_in ? shadow[bus.spi_addr[7:0]] : 8'h00;
            end
        end
        if (m_m) begin
            nx.m_rv   = 1'b1;
            nx.m_err  = !m_in;
            nx.m_data = m_in ? shadow[bus.mod_addr[7:0]] : 8'h00;
        end
        sb_q.push_back(nx);
        if (x_we) shadow[bus.spi_addr[7:0]] = bus.spi_wdata;

        if (m_m) begin
            m_wait   = 0;
            m_modpri = 1'b0;
        end else if (bus.mod_req) begin
            if (m_wait < MAX_WAIT) m_wait++;
            if (m_wait == MAX_WAIT) m_modpri = 1'b1;
        end

        @(posedge tb_clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        spi_access(1'b1, 10'h005, 8'hFF);
        mod_read(10'h006);
        repeat (2) @(negedge tb_clk);
        n_cmp++;
        if ({bus.spi_gnt, bus.mod_gnt, bus.mem_en, bus.mem_we} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_gnt: got gnt=%b%b en=%b we=%b, want all 0",
                     bus.spi_gnt, bus.mod_gnt, bus.mem_en, bus.mem_we);
        end
        n_cmp++;
        if ({bus.spi_rvalid, bus.spi_err, bus.mod_rvalid, bus.mod_err} !== 4'b0000 ||
            bus.spi_rdata !== 8'h00 || bus.mod_rdata !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_resp: got srv=%b serr=%b srd=%h mrv=%b merr=%b mrd=%h, want all 0",
                     bus.spi_rvalid, bus.spi_err, bus.spi_rdata, bus.mod_rvalid, bus.mod_err, bus.mod_rdata);
        end
        idle_inputs();
        @(posedge tb_clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_write_read();
        spi_access(1'b1, 10'h005, 8'hA5);
        tick();
        spi_access(1'b0, 10'h005, 8'h00);
        tick();
        n_cmp++;
        if (obs_s_rv !== 1'b0) begin
            n_bad++;
            $display("FAIL write_no_rvalid: got rvalid=%b, want 0", obs_s_rv);
        end
        idle_inputs();
        tick();
        n_cmp++;
        if (obs_s_rv !== 1'b1 || obs_s_rd !== 8'hA5 || obs_s_err !== 1'b0) begin
            n_bad++;
            $display("FAIL write_read: got rv=%b rd=%h err=%b, want rv=1 rd=a5 err=0",
                     obs_s_rv, obs_s_rd, obs_s_err);
        end
    endtask

    task automatic test_priority();
        logic exp_mod;
        spi_access(1'b0, 10'h005, 8'h00);
        mod_read(10'h006);
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_mod = ((i % 5) == 4);
            n_cmp++;
            if ({obs_spi_gnt, obs_mod_gnt} !== {!exp_mod, exp_mod}) begin
                n_bad++;
                $display("FAIL priority cycle %0d: got spi=%b mod=%b, want spi=%b mod=%b",
                         i, obs_spi_gnt, obs_mod_gnt, !exp_mod, exp_mod);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_out_of_range();
        spi_access(1'b1, 10'h0FF, 8'h12);
        tick();
        spi_access(1'b0, 10'h100, 8'h00);
        tick();
        n_cmp++;
        if (obs_spi_gnt !== 1'b1 || obs_mem_en !== 1'b0) begin
            n_bad++;
            $display("FAIL oor_read_grant: got gnt=%b mem_en=%b, want gnt=1 mem_en=0", obs_spi_gnt, obs_mem_en);
        end
        spi_access(1'b1, 10'h3FF, 8'h77);
        tick();
        n_cmp++;
        if (obs_s_rv !== 1'b1 || obs_s_rd !== 8'h00 || obs_s_err !== 1'b1) begin
            n_bad++;
            $display("FAIL oor_read_resp: got rv=%b rd=%h err=%b, want rv=1 rd=00 err=1",
                     obs_s_rv, obs_s_rd, obs_s_err);
        end
        mod_read(10'h2FF);
        idle_inputs();
        mod_read(10'h2FF);
        tick();
        n_cmp++;
        if (obs_s_rv !== 1'b0 || obs_s_err !== 1'b1) begin
            n_bad++;
            $display("FAIL oor_write_resp: got rv=%b err=%b, want rv=0 err=1", obs_s_rv, obs_s_err);
        end
        spi_access(1'b0, 10'h0FF, 8'h00);
        tick();
        n_cmp++;
        if (obs_m_rv !== 1'b1 || obs_m_rd !== 8'h00 || obs_m_err !== 1'b1 || obs_s_err !== 1'b0) begin
            n_bad++;
            $display("FAIL oor_mod_resp: got mrv=%b mrd=%h merr=%b serr=%b, want 1 00 1 0",
                     obs_m_rv, obs_m_rd, obs_m_err, obs_s_err);
        end
        idle_inputs();
        repeat (3) tick();
        n_cmp++;
        if (obs_s_rv !== 1'b0 || obs_s_rd !== 8'h12) begin
            n_bad++;
            $display("FAIL rdata_hold: got rv=%b rd=%h, want rv=0 rd=12", obs_s_rv, obs_s_rd);
        end
    endtask

    task automatic test_raw();
        spi_access(1'b1, 10'h07F, 8'h3C);
        tick();
        idle_inputs();
        mod_read(10'h07F);
        tick();
        idle_inputs();
        tick();
        n_cmp++;
        if (obs_m_rv !== 1'b1 || obs_m_rd !== 8'h3C || obs_m_err !== 1'b0) begin
            n_bad++;
            $display("FAIL raw: got rv=%b rd=%h err=%b, want rv=1 rd=3c err=0", obs_m_rv, obs_m_rd, obs_m_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] seq [4];
        int         n_rv = 0;
        seq = '{10'h005, 10'h0FF, 10'h07F, 10'h005};
        for (int i = 0; i < 5; i++) begin
            if (i < 4) spi_access(1'b0, seq[i], 8'h00);
            else       idle_inputs();
            tick();
            if (i > 0 && obs_s_rv === 1'b1) n_rv++;
        end
        n_cmp++;
        if (n_rv != 4) begin
            n_bad++;
            $display("FAIL back_to_back: got %0d rvalid cycles, want 4", n_rv);
        end
    endtask

    task automatic test_reset_mid();
        spi_access(1'b0, 10'h005, 8'h00);
        mod_read(10'h006);
        repeat (4) tick();
        rst_n = 1'b0;
        @(negedge tb_clk);
        n_cmp++;
        if ({bus.spi_rvalid, bus.spi_err, bus.spi_gnt, bus.mod_gnt, bus.mem_en} !== 5'b0 ||
            bus.spi_rdata !== 8'h00 || bus.mod_rdata !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid: got rv=%b err=%b gnt=%b%b en=%b srd=%h mrd=%h, want all 0",
                     bus.spi_rvalid, bus.spi_err, bus.spi_gnt, bus.mod_gnt, bus.mem_en,
                     bus.spi_rdata, bus.mod_rdata);
        end
        @(posedge tb_clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        tick();
        n_cmp++;
        if (obs_spi_gnt !== 1'b1 || obs_s_rv !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_spi_pri: got spi_gnt=%b rvalid=%b, want gnt=1 rvalid=0", obs_spi_gnt, obs_s_rv);
        end
        repeat (4) tick();
        n_cmp++;
        if (obs_mod_gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_wait_cnt: got mod_gnt=%b on 5th cycle, want 1", obs_mod_gnt);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random_fill();
        int idx = 0;
        int cyc = 0;
        int n_err = 0;
        for (int a = 0; a < 256; a++) begin
            spi_access(1'b1, 10'(a), 8'($urandom_range(0, 255)));
            tick();
        end
        while (idx < 256 && cyc < 2000) begin
            spi_access(1'b0, 10'(idx), 8'h00);
            bus.mod_req  = 1'($urandom_range(0, 1));
            bus.mod_addr = 10'($urandom_range(0, 255));
            tick();
            cyc++;
            if (obs_s_err === 1'b1 || obs_m_err === 1'b1) n_err++;
            if (obs_spi_gnt === 1'b1) idx++;
        end
        n_cmp++;
        if (idx != 256) begin
            n_bad++;
            $display("FAIL random_budget: got %0d reads granted in %0d cycles, want 256", idx, cyc);
        end
        idle_inputs();
        repeat (2) begin
            tick();
            if (obs_s_err === 1'b1 || obs_m_err === 1'b1) n_err++;
        end
        n_cmp++;
        if (n_err != 0) begin
            n_bad++;
            $display("FAIL random_err: got %0d err pulses, want 0", n_err);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) begin
            mem[a]    = 8'h00;
            shadow[a] = 8'h00;
        end
        bus.mem_rdata = 8'h00;
        idle_inputs();
        test_reset();
        test_write_read();
        test_priority();
        test_out_of_range();
        test_raw();
        test_back_to_back();
        test_reset_mid();
        test_random_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
